// File: rtl/aff7seg_pkg.sv
// Shared constants and helpers for the multiplexed hex 7-segment driver.
// Contents:
//   SEG_OFF / SEG_ALL : segment vectors in active-high form, index 0 = segment a
//   SEG_TABLE         : 16-entry nibble-to-segment table (active-high, a..g)
//   idx_width()       : digit pointer width for a given digit count
package aff7seg_pkg;

    localparam logic [0:6] SEG_OFF = 7'b0000000;
    localparam logic [0:6] SEG_ALL = 7'b1111111;

    localparam logic [0:6] SEG_TABLE [16] = '{
        7'b1111110,  // 0
        7'b0110000,  // 1
        7'b1101101,  // 2
        7'b1111001,  // 3
        7'b0110011,  // 4
        7'b1011011,  // 5
        7'b1011111,  // 6
        7'b1110000,  // 7
        7'b1111111,  // 8
        7'b1111011,  // 9
        7'b1110111,  // A
        7'b0011111,  // b
        7'b1001110,  // C
        7'b0111101,  // d
        7'b1001111,  // E
        7'b1000111   // F
    };

    // Width of the digit pointer; at least one bit even for a single digit.
    function automatic int unsigned idx_width(input int unsigned nb_digits);
        return (nb_digits > 1) ? $clog2(nb_digits) : 1;
    endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational nibble-to-segment decoder, active-high output.
// Ports:
//   nibble_i : hex digit value 0..F
//   seg_o    : segments a..g, seg_o[0] = a, '1' = lit
module hex_to_7seg
    import aff7seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [0:6] seg_o
);

    assign seg_o = SEG_TABLE[nibble_i];

endmodule

// File: rtl/aff7seg_hexa_mux.sv
// Time-multiplexed hexadecimal 7-segment driver for an N-digit display.
// A shadow register holds the nibbles; a prescaler divides each digit slot
// into CLK_DIV cycles, the first of which is dark to avoid ghosting.
// Optional build macro: LEADING_ZERO_BLANK_EN darkens leading zero digits
// (digit 0 is always shown).
// Ports:
//   Clk   : system clock, rising edge
//   nRst  : asynchronous active-low reset
//   Data  : packed nibbles, Data[3:0] is digit 0
//   Load  : copy Data into the shadow register at the clock edge
//   Blank : force all digits dark
//   Seg   : registered segments a..g (Seg[0] = a), polarity per SEG_POLARITY
//   An    : registered digit enables, An[i] = digit i, polarity per AN_POLARITY
module aff7seg_hexa_mux
    import aff7seg_pkg::*;
#(
    parameter int unsigned NB_DIGITS    = 4,
    parameter int unsigned CLK_DIV      = 50000,
    parameter int unsigned SEG_POLARITY = 1,
    parameter int unsigned AN_POLARITY  = 0
) (
    input  logic                     Clk,
    input  logic                     nRst,
    input  logic [4*NB_DIGITS-1:0]   Data,
    input  logic                     Load,
    input  logic                     Blank,
    output logic [0:6]               Seg,
    output logic [NB_DIGITS-1:0]     An
);

    localparam int unsigned IdxW = idx_width(NB_DIGITS);
    localparam int unsigned PreW = $clog2(CLK_DIV);

    localparam logic [PreW-1:0]      PreLast = PreW'(CLK_DIV - 1);
    localparam logic [IdxW-1:0]      IdxLast = IdxW'(NB_DIGITS - 1);
    localparam logic [0:6]           SegDark = (SEG_POLARITY != 0) ? SEG_OFF : ~SEG_OFF;
    localparam logic [NB_DIGITS-1:0] AnDark  = (AN_POLARITY != 0) ? '0 : '1;

    logic [PreW-1:0]          prescaler_q, prescaler_d;
    logic [IdxW-1:0]          index_q, index_d;
    logic [4*NB_DIGITS-1:0]   shadow_q, shadow_d;
    logic [0:6]               seg_q, seg_d;
    logic [NB_DIGITS-1:0]     an_q, an_d;

    logic [3:0]               nibble;
    logic [0:6]               seg_hi;
    logic [NB_DIGITS-1:0]     an_onehot;
    logic                     digit_on;

    hex_to_7seg u_dec (
        .nibble_i (nibble),
        .seg_o    (seg_hi)
    );

`ifdef LEADING_ZERO_BLANK_EN
    // zero_from[i] is set when nibbles NB_DIGITS-1..i are all zero.
    logic [NB_DIGITS-1:0] zero_from;

    always_comb begin
        logic all_zero;
        all_zero  = 1'b1;
        zero_from = '0;
        for (int i = int'(NB_DIGITS) - 1; i >= 0; i--) begin
            all_zero     = all_zero & (shadow_q[4*i +: 4] == 4'h0);
            zero_from[i] = all_zero;
        end
    end
`endif

    always_comb begin
        prescaler_d = (prescaler_q == PreLast) ? '0 : prescaler_q + 1'b1;

        index_d = index_q;
        if (prescaler_q == PreLast) begin
            index_d = (index_q == IdxLast) ? '0 : index_q + 1'b1;
        end

        shadow_d = Load ? Data : shadow_q;

        // Outputs are computed from pre-edge state, so a Load shows one cycle later.
        nibble = shadow_q[4*int'(index_q) +: 4];

        an_onehot          = '0;
        an_onehot[index_q] = 1'b1;

        // Prescaler value 0 is the dark guard cycle of each slot.
        digit_on = (prescaler_q != '0) && !Blank;
`ifdef LEADING_ZERO_BLANK_EN
        if (index_q != '0 && zero_from[index_q]) begin
            digit_on = 1'b0;
        end
`endif

        seg_d = digit_on ? seg_hi : SEG_OFF;
        if (SEG_POLARITY == 0) begin
            seg_d = ~seg_d;
        end

        an_d = digit_on ? an_onehot : '0;
        if (AN_POLARITY == 0) begin
            an_d = ~an_d;
        end
    end

    always_ff @(posedge Clk or negedge nRst) begin
        if (!nRst) begin
            prescaler_q <= '0;
            index_q     <= '0;
            shadow_q    <= '0;
            seg_q       <= SegDark;
            an_q        <= AnDark;
        end else begin
            prescaler_q <= prescaler_d;
            index_q     <= index_d;
            shadow_q    <= shadow_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
        end
    end

    assign Seg = seg_q;
    assign An  = an_q;

endmodule

// File: doc/aff7seg_hexa_mux.md
# aff7seg_hexa_mux

Time-multiplexed hexadecimal 7-segment driver for an N-digit common-anode/cathode display. Latches a packed nibble vector and scans it one digit at a time through shared segment lines and per-digit enables. It inserts a dark cycle between digits to prevent ghosting. It sits between the datapath registers and the board's display pins, replacing the per-digit static decoders.

## Interface
- NB_DIGITS, 4: number of digits; legal 1..8.
- CLK_DIV, 50000: clock cycles per digit slot; legal ≥ 2.
- SEG_POLARITY, 1: 1 means a segment is lit when its bit is '1'; 0 means lit when '0'.
- AN_POLARITY, 0: 1 means a digit is enabled when its An bit is '1'; 0 means enabled when '0'.

- Clk  in  1  system clock; all state changes on its rising edge.
- nRst  in  1  asynchronous, active-low reset.
- Data  in  4*NB_DIGITS  packed nibbles; Data[3:0] is digit 0 (rightmost, least significant).
- Load  in  1  when high at a clock edge, Data is copied into the shadow register.
- Blank  in  1  when high, all digits are dark.
- Seg  out  [0:6]  segments a..g, with Seg[0]=a.
- An  out  NB_DIGITS  digit enables; An[i] drives digit i.

## Operation
- Segment table (a..g, active-high form), by nibble value:
  - 0:1111110, 1:0110000, 2:1101101, 3:1111001, 4:0110011, 5:1011011, 6:1011111, 7:1110000
  - 8:1111111, 9:1111011, A:1110111, b:0011111, C:1001110, d:0111101, E:1001111, F:1000111
- Seg is inverted when SEG_POLARITY=0. An is inverted relative to one-hot when AN_POLARITY=0.
- Shadow register: loaded on any edge with Load=1, independent of scan state and Blank.
- Prescaler: counts 0..CLK_DIV-1 and wraps to 0.
- Index: digit pointer, width max(1,$clog2(NB_DIGITS)).
  - Increments on the edge where Prescaler=CLK_DIV-1.
  - Wraps from NB_DIGITS-1 to 0.
- Seg and An are registered. Each cycle they are computed from the current Prescaler, Index, Shadow and Blank:
  - Prescaler=0 or Blank=1: all An inactive; Seg = all segments off.
  - Otherwise: An one-hot on Index; Seg = decoded Shadow nibble[Index].
- Simultaneous Load and Index advance: both take effect on the same edge. The next computed output uses the new shadow value.
- NB_DIGITS=1: Index stays 0; the dark cycle still occurs every CLK_DIV cycles.

## Timing
- Reset values (asynchronous): Prescaler=0, Index=0, Shadow=0, Seg=all off, An=all inactive.
- Output latency: 1 cycle from a state or input change to Seg/An.
  - After Load, the new nibble appears on Seg one cycle after the edge on which it is latched, if that digit is active.
  - Blank asserted: outputs go dark at the next edge. Blank released: the current digit resumes at the next edge, unless Prescaler=0.
- Per digit: lit for CLK_DIV-1 cycles, then dark for 1 cycle. Full scan period is NB_DIGITS*CLK_DIV cycles.
- First lit output after reset release: digit 0, on the 2nd rising edge.
- Reset asserted mid-scan: outputs go dark immediately and shadow content is lost. The scan restarts at digit 0.

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - A digit i > 0 is dark (An inactive, Seg off) when nibbles NB_DIGITS-1..i of Shadow are all zero.
  - Digit 0 is always shown.
  - The slot timing is unchanged; the blanked digit's slot still elapses.
- LEADING_ZERO_BLANK_EN undefined: every digit is shown, including leading zeros.

## Structure
- Package aff7seg_pkg holds:
  - the 16-entry segment table constant;
  - the SEG_OFF / SEG_ALL constants, in active-high form;
  - a function computing the Index width from NB_DIGITS.
- One sub-module: hex_to_7seg, a combinational nibble-to-segment decoder using the package table (active-high). Polarity inversion is applied in aff7seg_hexa_mux at the output register.

## Test plan
Bench configuration: NB_DIGITS=4, CLK_DIV=4, SEG_POLARITY=1, AN_POLARITY=0, unless stated otherwise.
- Reset: hold nRst=0 for 3 cycles -> Seg=0000000, An=1111. Release -> first lit output is An=1110, Seg=1111110 (digit 0 of shadow 0).
- Scan: Load Data=16'h1A3F, then free-run for 16 cycles -> observed sequence:
  - An=1110, Seg=1000111;
  - An=1101, Seg=1111001;
  - An=1011, Seg=1110111;
  - An=0111, Seg=0110000;
  - each lit 3 cycles, separated by 1 cycle of An=1111.
- Mid-slot Load: while digit 1 is lit, Load 16'h0020 -> the cycle after the Load edge, Seg=1101101 with An still 1101.
- Blank: assert Blank for 5 cycles mid-scan -> An=1111 during that window. The Index continues advancing, so the digit shown after release follows the scan schedule.
- Reset mid-scan: assert nRst=0 at digit 2 -> An=1111 and Seg=0000000 immediately. After release, the scan restarts at digit 0 showing 0.
- With LEADING_ZERO_BLANK_EN defined:
  - Data=16'h0005 -> only digit 0 lit (Seg=1011011); slots 1..3 dark.
  - Data=16'h0100 -> digits 0, 1, 2 lit (showing 0, 0, 1); digit 3 dark.
